// File: rtl/shared_ram_loader_pkg.sv
// Shared definitions for the host loader: RAM geometry (common with the multiport RAM
// and the cores) and the loader FSM state encoding.
package shared_ram_loader_pkg;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [3:0] {
        StIdle,
        StLoadLo,
        StLoadHi,
        StRun,
        StWait,
        StRd,
        StTxLo,
        StTxHi,
        StFinish
    } state_e;

endpackage

// File: rtl/shared_ram_loader_if.sv
// Byte-stream handshakes plus one shared-RAM port, as seen by the host loader.
interface shared_ram_loader_if;
    import shared_ram_loader_pkg::*;

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              ram_write_en;
    logic              ram_read_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;

    modport master (
        input  rx_data, rx_valid, tx_ready, ram_data_out,
        output rx_ready, tx_data, tx_valid, ram_write_en, ram_read_en, ram_addr, ram_data_in
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, ram_data_out,
        input  rx_ready, tx_data, tx_valid, ram_write_en, ram_read_en, ram_addr, ram_data_in
    );

endinterface

// File: rtl/shared_ram_loader_packer.sv
// Byte/word conversion: latches the low byte of an incoming pair and holds the word
// being streamed out, selecting its low or high byte.
module shared_ram_loader_packer
    import shared_ram_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              lo_load,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] packed_word,
    input  logic              word_load,
    input  logic [DATA_W-1:0] word_in,
    input  logic              hi_sel,
    output logic [7:0]        out_byte
);

    logic [7:0]        lo_q;
    logic [DATA_W-1:0] word_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lo_q   <= '0;
            word_q <= '0;
        end else begin
            if (lo_load) begin
                lo_q <= byte_in;
            end
            if (word_load) begin
                word_q <= word_in;
            end
        end
    end

    assign packed_word = {byte_in, lo_q};

    // RAM data is only valid from the first TX_LO cycle, so bypass the register then.
    always_comb begin
        if (hi_sel) begin
            out_byte = word_q[15:8];
        end else if (word_load) begin
            out_byte = word_in[7:0];
        end else begin
            out_byte = word_q[7:0];
        end
    end

endmodule

// File: rtl/shared_ram_loader.sv
// Host front end of the shared data RAM: loads a byte stream as little-endian words,
// releases the cores, waits for all done flags and streams a result window back out.
module shared_ram_loader
    import shared_ram_loader_pkg::*;
#(
    parameter int unsigned LOAD_WORDS = 512,
    parameter int unsigned CORES      = 16,
    parameter int unsigned DUMP_BASE  = 0,
    parameter int unsigned DUMP_WORDS = 512
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 go,
    shared_ram_loader_if.master  bus,
    output logic                 core_start,
    input  logic [CORES-1:0]     core_done,
    output logic                 busy,
    output logic                 done
);

    localparam logic [ADDR_W:0]   LoadLast = (ADDR_W + 1)'(LOAD_WORDS - 1);
    localparam logic [ADDR_W:0]   DumpLast = (ADDR_W + 1)'(DUMP_WORDS - 1);
    localparam logic [ADDR_W:0]   CntOne   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] DumpBase = ADDR_W'(DUMP_BASE);

    state_e            state_q;
    logic [ADDR_W:0]   cnt_q;
    logic              fresh_q;

    logic              in_load;
    logic              wr_en;
    logic              rd_en;
    logic              lo_load;
    logic              word_load;
    logic [DATA_W-1:0] packed_word;
    logic [7:0]        out_byte;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            fresh_q <= 1'b0;
        end else begin
            fresh_q <= 1'b0;
            unique case (state_q)
                StIdle, StFinish: begin
                    if (go) begin
                        cnt_q   <= '0;
                        state_q <= StLoadLo;
                    end
                end
                StLoadLo: begin
                    if (bus.rx_valid) begin
                        state_q <= StLoadHi;
                    end
                end
                StLoadHi: begin
                    if (bus.rx_valid) begin
                        if (cnt_q == LoadLast) begin
                            state_q <= StRun;
                        end else begin
                            cnt_q   <= cnt_q + CntOne;
                            state_q <= StLoadLo;
                        end
                    end
                end
                StRun: state_q <= StWait;
                StWait: begin
                    if (&core_done) begin
                        cnt_q   <= '0;
                        state_q <= StRd;
                    end
                end
                StRd: begin
                    fresh_q <= 1'b1;
                    state_q <= StTxLo;
                end
                StTxLo: begin
                    if (bus.tx_ready) begin
                        state_q <= StTxHi;
                    end
                end
                StTxHi: begin
                    if (bus.tx_ready) begin
                        if (cnt_q == DumpLast) begin
                            state_q <= StFinish;
                        end else begin
                            cnt_q   <= cnt_q + CntOne;
                            state_q <= StRd;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs are gated by rstn so nothing reaches the RAM or the cores in a reset cycle.
    assign in_load   = (state_q == StLoadLo) || (state_q == StLoadHi);
    assign wr_en     = rstn && (state_q == StLoadHi) && bus.rx_valid;
    assign rd_en     = rstn && (state_q == StRd);
    assign lo_load   = (state_q == StLoadLo) && bus.rx_valid;
    assign word_load = (state_q == StTxLo) && fresh_q;

    shared_ram_loader_packer u_packer (
        .clk         (clk),
        .rstn        (rstn),
        .lo_load     (lo_load),
        .byte_in     (bus.rx_data),
        .packed_word (packed_word),
        .word_load   (word_load),
        .word_in     (bus.ram_data_out),
        .hi_sel      (state_q == StTxHi),
        .out_byte    (out_byte)
    );

    always_comb begin
        bus.ram_addr    = '0;
        bus.ram_data_in = '0;
        if (wr_en) begin
            bus.ram_addr    = cnt_q[ADDR_W-1:0];
            bus.ram_data_in = packed_word;
        end else if (rd_en) begin
            bus.ram_addr = DumpBase + cnt_q[ADDR_W-1:0];
        end
    end

    assign bus.ram_write_en = wr_en;
    assign bus.ram_read_en  = rd_en;
    assign bus.rx_ready     = rstn && in_load;
    assign bus.tx_valid     = rstn && ((state_q == StTxLo) || (state_q == StTxHi));
    assign bus.tx_data      = bus.tx_valid ? out_byte : 8'h00;
    assign core_start       = rstn && (state_q == StRun);
    assign busy             = rstn && (state_q != StIdle);
    assign done             = rstn && (state_q == StFinish);

endmodule
